led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
- Bus-side controller in front of the LED output driver. It owns the driver's write-enable and write-data path.
- The CPU either writes a static pattern, or arms an autonomous engine that blinks or rotates the pattern every PERIOD clocks.
- Sits between the CPU bridge and the driver. When a CPU write and an engine update collide, the CPU write wins.

Parameters:
- WIDTH, 32, LED pattern width in bits; also the bus data width.
- CNT_W, 32, width of the period counter and the PERIOD register.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- addr  input  2  register select: 0 CTRL, 1 PERIOD, 2 PATTERN, 3 STATUS.
- WE  input  1  bus write strobe, one cycle per write.
- Din  input  WIDTH  bus write data.
- Dout  output  WIDTH  combinational read data for the selected register.
- led_we  output  1  one-cycle write pulse to the LED driver.
- led_din  output  WIDTH  pattern to the LED driver; 1 = LED lit. Registered.

Behaviour:
- Registers:
  - CTRL[1:0] is mode: 0 manual, 1 blink, 2 rotate-left, 3 rotate-right. CTRL[2] is run. Other CTRL bits read 0.
  - PERIOD is CNT_W bits.
  - PATTERN is WIDTH bits.
  - STATUS reads the currently displayed value (shadow of led_din). STATUS is read-only except as noted under the optional feature.
- Reset (reset low): CTRL=0, PERIOD=0, PATTERN=0, shadow=0, cnt=0, blink phase=0, led_we=0, led_din=0, state=IDLE. Dout follows the reset register values.
- States:
  - IDLE: engine stopped.
  - RUN: counting.
  - UPD: one cycle issuing the engine update.
- Transitions:
  - IDLE->RUN when run=1, mode!=0 and PERIOD!=0. cnt loads PERIOD-1.
  - RUN: cnt decrements each clock. At cnt==0 go to UPD.
  - UPD: update issued, cnt reloads PERIOD-1, return to RUN.
  - Any state->IDLE when run=0, mode=0 or PERIOD=0 (evaluated on registered values).
- Engine update in UPD:
  - Blink: phase toggles. led_din = phase ? 0 : PATTERN (phase 0 shows PATTERN).
  - Rotate-left: PATTERN <= {PATTERN[WIDTH-2:0], PATTERN[WIDTH-1]}, and led_din gets the rotated value.
  - Rotate-right: symmetric rotate in the other direction.
  - Every update asserts led_we for exactly one cycle.
- CPU write to PATTERN:
  - The register updates on the write edge.
  - On the next cycle led_we=1 and led_din=Din, in every mode.
  - Blink phase resets to 0. cnt reloads PERIOD-1 if the state is RUN or UPD.
- CPU write to CTRL or PERIOD:
  - The register updates; cnt reloads from the new PERIOD-1; blink phase resets to 0.
  - No led_we pulse.
  - Entering manual mode leaves led_din unchanged.
- Collision: if a CPU PATTERN write and UPD fall in the same cycle, only the CPU write takes effect. The engine update is dropped (no rotate, no phase toggle) and the counter reloads.
- Latency:
  - Bus write to led_we: 1 cycle.
  - Arming to first engine update: PERIOD+1 cycles after the CTRL write edge.
- PERIOD=1: an update every 2 cycles (RUN, UPD alternate).
- Width rules:
  - The counter is unsigned and never wraps below 0.
  - PERIOD is taken modulo 2^CNT_W.
- Reset mid-operation: everything returns to reset values asynchronously. led_we drops immediately.

Optional Feature:
- Macro: LED_SEQ_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) and a sticky STATUS-side flag, tick_flag.
  - tick_flag sets on every UPD that is not dropped, and irq = tick_flag.
  - A write of any value to addr 3 clears tick_flag. If the clear coincides with an update, set wins.
  - Reading addr 3 returns {tick_flag, shadow[WIDTH-2:0]}.
  - Reset clears tick_flag.
- When undefined: no irq port, no flag logic, and addr 3 writes are ignored.

Test Plan:
- Reset low mid-blink with led_we high -> led_we=0, led_din=0, Dout(CTRL)=0 without a clock edge. After release, IDLE and no led_we.
- Manual mode, write PATTERN=0x0000_00A5 -> next cycle led_we=1 for one cycle, led_din=0x0000_00A5. STATUS reads 0x0000_00A5.
- PATTERN=0x8000_0001, PERIOD=4, CTRL=0x6 (rotate-left, run) -> led_we pulses at cycles 5, 10 and 15 after the CTRL edge, with led_din 0x0000_0003, 0x0000_0006, 0x0000_000C.
- Blink with PATTERN=0xF0F0_F0F0, PERIOD=2 -> led_din alternates 0x0000_0000 / 0xF0F0_F0F0, one pulse every 3 cycles. Writing CTRL run=0 -> no further pulses and led_din holds.
- Collision: rotate mode, CPU writes PATTERN=0x1 in the UPD cycle -> led_din=0x1 next cycle (not rotated). The next update yields 0x2 after PERIOD+1 cycles.
- With LED_SEQ_IRQ_EN: first update -> irq=1. Write addr 3 -> irq=0 next cycle. A clear coinciding with an update -> irq stays 1.

Source files
------------

// File: rtl/led_sequencer_if.sv
// CPU-side register bus for the LED sequencer: register select, write strobe,
// write data and combinational read data.
interface led_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       addr;
  logic             WE;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Dout;

  modport master (output addr, WE, Din, input Dout);
  modport slave  (input addr, WE, Din, output Dout);
endinterface

// File: rtl/led_sequencer.sv
// LED driver front end: CPU writes a static pattern or arms a blink/rotate engine.
// Optional macro LED_SEQ_IRQ_EN adds a sticky update flag and the irq output.
module led_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  led_sequencer_if.slave   bus,
  output logic             led_we,
  output logic [WIDTH-1:0] led_din
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic             irq
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, UPD} state_t;

  state_t           state;
  logic [1:0]       mode;
  logic             run;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pattern;
  logic             phase;

  logic             ctrl_wr;
  logic             period_wr;
  logic             pattern_wr;
  logic             reload;
  logic [1:0]       mode_next;
  logic             run_next;
  logic [CNT_W-1:0] period_next;
  logic [CNT_W-1:0] reload_val;
  logic             armed;
  logic             armed_next;
  logic             upd_fire;
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;

  assign ctrl_wr    = bus.WE && (bus.addr == 2'd0);
  assign period_wr  = bus.WE && (bus.addr == 2'd1);
  assign pattern_wr = bus.WE && (bus.addr == 2'd2);
  assign reload     = ctrl_wr || period_wr || pattern_wr;

  // Arming from IDLE sees the values being written; leaving to IDLE sees the stored ones.
  assign mode_next   = ctrl_wr ? bus.Din[1:0] : mode;
  assign run_next    = ctrl_wr ? bus.Din[2] : run;
  assign period_next = period_wr ? CNT_W'(bus.Din) : period;
  assign reload_val  = (period_next == '0) ? '0 : period_next - CNT_W'(1);
  assign armed       = run && (mode != 2'd0) && (period != '0);
  assign armed_next  = run_next && (mode_next != 2'd0) && (period_next != '0);

  // A PATTERN write in the UPD cycle pre-empts the engine update.
  assign upd_fire  = (state == UPD) && armed && !pattern_wr;
  assign rot_left  = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
  assign rot_right = {pattern[0], pattern[WIDTH-1:1]};

`ifdef LED_SEQ_IRQ_EN
  logic tick_flag;
  logic status_wr;

  assign status_wr = bus.WE && (bus.addr == 2'd3);
  assign irq       = tick_flag;
`endif

  always_comb begin
    bus.Dout = '0;
    case (bus.addr)
      2'd0:    bus.Dout = WIDTH'({run, mode});
      2'd1:    bus.Dout = WIDTH'(period);
      2'd2:    bus.Dout = pattern;
`ifdef LED_SEQ_IRQ_EN
      default: bus.Dout = {tick_flag, led_din[WIDTH-2:0]};
`else
      default: bus.Dout = led_din;
`endif
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode      <= 2'd0;
      run       <= 1'b0;
      period    <= '0;
      cnt       <= '0;
      pattern   <= '0;
      phase     <= 1'b0;
      led_we    <= 1'b0;
      led_din   <= '0;
`ifdef LED_SEQ_IRQ_EN
      tick_flag <= 1'b0;
`endif
    end else begin
      led_we <= 1'b0;

      case (state)
        IDLE: begin
          if (armed_next) begin
            state <= RUN;
            cnt   <= reload_val;
          end else if (ctrl_wr || period_wr) begin
            cnt <= reload_val;
          end
        end
        RUN: begin
          if (!armed) begin
            state <= IDLE;
          end else if (reload) begin
            cnt <= reload_val;
          end else if (cnt == '0) begin
            state <= UPD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        UPD: begin
          if (!armed) begin
            state <= IDLE;
          end else begin
            state <= RUN;
            cnt   <= reload_val;
          end
          if (upd_fire) begin
            led_we <= 1'b1;
            case (mode)
              2'd1: begin
                phase   <= ~phase;
                led_din <= phase ? pattern : '0;
              end
              2'd2: begin
                pattern <= rot_left;
                led_din <= rot_left;
              end
              2'd3: begin
                pattern <= rot_right;
                led_din <= rot_right;
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase

      // CPU writes come last so they override any engine effect in the same cycle.
      if (ctrl_wr) begin
        mode  <= bus.Din[1:0];
        run   <= bus.Din[2];
        phase <= 1'b0;
      end
      if (period_wr) begin
        period <= CNT_W'(bus.Din);
        phase  <= 1'b0;
      end
      if (pattern_wr) begin
        pattern <= bus.Din;
        led_din <= bus.Din;
        led_we  <= 1'b1;
        phase   <= 1'b0;
      end

`ifdef LED_SEQ_IRQ_EN
      if (upd_fire) begin
        tick_flag <= 1'b1;
      end else if (status_wr) begin
        tick_flag <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: register vector table, scripted engine scenarios and
// randomized bus traffic compared against a countdown-based reference model.
module tb_led_sequencer;

  logic        clk;
  logic        reset;
  logic        led_we;
  logic [31:0] led_din;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  led_sequencer_if #(.WIDTH(32)) bus ();

  led_sequencer #(.WIDTH(32), .CNT_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .led_we  (led_we),
    .led_din (led_din)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: registers plus "edges until the next engine update".
  logic [1:0]  m_mode;
  logic        m_run;
  logic [31:0] m_period;
  logic [31:0] m_pattern;
  logic [31:0] m_shadow;
  logic        m_phase;
  logic        m_flag;
  logic        m_we;
  bit          m_running;
  longint      m_ticks;

  typedef struct {
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic        exp_we;
    logic [31:0] exp_led;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] rot_exp [3];
  logic [31:0] blink_exp [3];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic model_reset();
    m_mode = 2'd0; m_run = 1'b0; m_period = 32'h0; m_pattern = 32'h0;
    m_shadow = 32'h0; m_phase = 1'b0; m_flag = 1'b0; m_we = 1'b0;
    m_running = 0; m_ticks = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {29'h0, m_run, m_mode};
      2'd1:    return m_period;
      2'd2:    return m_pattern;
`ifdef LED_SEQ_IRQ_EN
      default: return {m_flag, m_shadow[30:0]};
`else
      default: return m_shadow;
`endif
    endcase
  endfunction

  task automatic model_step(input logic [1:0] a, input logic w, input logic [31:0] d);
    bit     cw, pw, tw, sw, armed_old, armed_new, upd;
    longint p_new;
    cw = w && a == 2'd0; pw = w && a == 2'd1; tw = w && a == 2'd2; sw = w && a == 2'd3;
    armed_old = m_run && m_mode != 0 && m_period != 0;
    p_new     = pw ? longint'(d) : longint'(m_period);
    armed_new = (cw ? d[2] : m_run) && (cw ? d[1:0] : m_mode) != 0 && p_new != 0;
    upd  = 0;
    m_we = 1'b0;
    if (!m_running) begin
      if (armed_new) begin m_running = 1; m_ticks = p_new + 1; end
    end else if (!armed_old) begin
      m_running = 0;
    end else if (m_ticks == 1) begin
      upd = !tw;
      m_ticks = p_new + 1;
    end else if (cw || pw || tw) begin
      m_ticks = p_new + 1;
    end else begin
      m_ticks--;
    end
    if (upd) begin
      m_we = 1'b1;
      if (m_mode == 2'd1) begin
        m_phase  = !m_phase;
        m_shadow = m_phase ? 32'h0 : m_pattern;
      end else if (m_mode == 2'd2) begin
        m_pattern = (m_pattern << 1) | (m_pattern >> 31);
        m_shadow  = m_pattern;
      end else begin
        m_pattern = (m_pattern >> 1) | (m_pattern << 31);
        m_shadow  = m_pattern;
      end
    end
    if (cw) begin m_mode = d[1:0]; m_run = d[2]; m_phase = 1'b0; end
    if (pw) begin m_period = d; m_phase = 1'b0; end
    if (tw) begin m_pattern = d; m_shadow = d; m_we = 1'b1; m_phase = 1'b0; end
    if (upd) m_flag = 1'b1;
    else if (sw) m_flag = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [1:0] a, input logic w, input logic [31:0] d);
    bus.addr = a; bus.WE = w; bus.Din = d;
    @(posedge clk);
    #1;
    model_step(a, w, d);
  endtask

  task automatic idle(input logic [1:0] a);
    apply_stimulus(a, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0; bus.addr = 2'd0; bus.WE = 1'b0; bus.Din = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    bit found;
    logic [1:0]  ra;
    logic        rw;
    logic [31:0] rd;

    vecs[0] = '{2'd0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{2'd2, 1'b1, 32'h0000_00A5, 1'b1, 32'h0000_00A5, 32'h0000_00A5};
    vecs[2] = '{2'd3, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_00A5, 32'h0000_00A5};
    vecs[3] = '{2'd1, 1'b1, 32'h0000_0007, 1'b0, 32'h0000_00A5, 32'h0000_0007};
    vecs[4] = '{2'd0, 1'b1, 32'hFFFF_FFF3, 1'b0, 32'h0000_00A5, 32'h0000_0003};
    vecs[5] = '{2'd0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_00A5, 32'h0000_0003};
    vecs[6] = '{2'd2, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 32'h1234_5678};
    vecs[7] = '{2'd0, 1'b1, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'h0000_0000};
    vecs[8] = '{2'd1, 1'b1, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'h0000_0000};
    rot_exp   = '{32'h0000_0003, 32'h0000_0006, 32'h0000_000C};
    blink_exp = '{32'h0000_0000, 32'hF0F0_F0F0, 32'h0000_0000};

    do_reset();
    check_output("reset_led_we", led_we, 32'h0);
    check_output("reset_led_din", led_din, 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus.addr = 2'(a);
      #1;
      check_output($sformatf("reset_dout_addr%0d", a), bus.Dout, 32'h0);
    end

    // Register vector table: manual mode writes and readback masking.
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].addr, vecs[i].we, vecs[i].din);
      check_output($sformatf("vec%0d_led_we", i), led_we, 32'(vecs[i].exp_we));
      check_output($sformatf("vec%0d_led_din", i), led_din, vecs[i].exp_led);
      check_output($sformatf("vec%0d_dout", i), bus.Dout, vecs[i].exp_dout);
    end

    // Rotate-left, PERIOD=4: pulses 5, 10 and 15 cycles after the CTRL edge.
    do_reset();
    apply_stimulus(2'd2, 1'b1, 32'h8000_0001);
    apply_stimulus(2'd1, 1'b1, 32'd4);
    apply_stimulus(2'd0, 1'b1, 32'h6);
    for (int k = 1; k <= 15; k++) begin
      idle(2'd3);
      if (k % 5 == 0) begin
        check_output($sformatf("rotl_we_c%0d", k), led_we, 32'h1);
        check_output($sformatf("rotl_din_c%0d", k), led_din, rot_exp[k/5-1]);
      end else begin
        check_output($sformatf("rotl_quiet_c%0d", k), led_we, 32'h0);
      end
    end

    // Blink, PERIOD=2, then stop: led_din must hold with no pulses.
    do_reset();
    apply_stimulus(2'd2, 1'b1, 32'hF0F0_F0F0);
    apply_stimulus(2'd1, 1'b1, 32'd2);
    apply_stimulus(2'd0, 1'b1, 32'h5);
    for (int k = 1; k <= 9; k++) begin
      idle(2'd3);
      if (k % 3 == 0) begin
        check_output($sformatf("blink_we_c%0d", k), led_we, 32'h1);
        check_output($sformatf("blink_din_c%0d", k), led_din, blink_exp[k/3-1]);
      end else begin
        check_output($sformatf("blink_quiet_c%0d", k), led_we, 32'h0);
      end
    end
    apply_stimulus(2'd0, 1'b1, 32'h1);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (led_we) pulses++;
      idle(2'd0);
    end
    check_output("blink_stop_pulses", 32'(pulses), 32'h0);
    check_output("blink_stop_hold", led_din, 32'h0);

    // Collision: PATTERN write lands in the UPD cycle.
    do_reset();
    apply_stimulus(2'd2, 1'b1, 32'h0000_0010);
    apply_stimulus(2'd1, 1'b1, 32'd3);
    apply_stimulus(2'd0, 1'b1, 32'h6);
    repeat (3) idle(2'd2);
    apply_stimulus(2'd2, 1'b1, 32'h1);
    check_output("collide_we", led_we, 32'h1);
    check_output("collide_din", led_din, 32'h1);
    for (int k = 1; k <= 3; k++) begin
      idle(2'd2);
      check_output($sformatf("collide_quiet_%0d", k), led_we, 32'h0);
    end
    idle(2'd2);
    check_output("collide_next_we", led_we, 32'h1);
    check_output("collide_next_din", led_din, 32'h2);

`ifdef LED_SEQ_IRQ_EN
    do_reset();
    apply_stimulus(2'd2, 1'b1, 32'h1);
    apply_stimulus(2'd1, 1'b1, 32'd2);
    apply_stimulus(2'd0, 1'b1, 32'h6);
    idle(2'd3);
    idle(2'd3);
    check_output("irq_before", irq, 32'h0);
    idle(2'd3);
    check_output("irq_first", irq, 32'h1);
    check_output("irq_status", bus.Dout, 32'h8000_0002);
    apply_stimulus(2'd3, 1'b1, 32'h0);
    check_output("irq_cleared", irq, 32'h0);
    idle(2'd3);
    apply_stimulus(2'd3, 1'b1, 32'h0);
    check_output("irq_set_wins", irq, 32'h1);
`endif

    // Asynchronous reset while led_we is high in blink mode.
    do_reset();
    apply_stimulus(2'd2, 1'b1, 32'h0000_00FF);
    apply_stimulus(2'd1, 1'b1, 32'd1);
    apply_stimulus(2'd0, 1'b1, 32'h5);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      idle(2'd0);
      if (led_we) found = 1;
    end
    check_output("areset_saw_pulse", 32'(found), 32'h1);
    #1;
    bus.addr = 2'd0; bus.WE = 1'b0; bus.Din = 32'h0;
    reset = 1'b0;
    #1;
    check_output("areset_led_we", led_we, 32'h0);
    check_output("areset_led_din", led_din, 32'h0);
    check_output("areset_dout_ctrl", bus.Dout, 32'h0);
    #2;
    reset = 1'b1;
    model_reset();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      idle(2'd0);
      if (led_we) pulses++;
    end
    check_output("areset_idle_pulses", 32'(pulses), 32'h0);

    // Randomized bus traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ra = 2'($urandom_range(0, 3));
      rw = ($urandom_range(0, 9) < 4);
      rd = $urandom();
      if (ra == 2'd1) rd = $urandom_range(0, 4);
      if (ra == 2'd0) rd[2] = ($urandom_range(0, 3) != 0);
      apply_stimulus(ra, rw, rd);
      check_output($sformatf("rand%0d_led_we", i), led_we, 32'(m_we));
      check_output($sformatf("rand%0d_led_din", i), led_din, m_shadow);
      check_output($sformatf("rand%0d_dout", i), bus.Dout, model_read(ra));
`ifdef LED_SEQ_IRQ_EN
      check_output($sformatf("rand%0d_irq", i), irq, 32'(m_flag));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
